// File: rtl/cube_pkg.sv
// cube_pkg: shared constants and types for the facelet colour store and scan.
//   NUM_FACELETS / COLOR_W / IDX_W  - store geometry
//   COLOR_RESET                     - colour value after reset (all ones)
//   FACE_*                          - first facelet index of each face
//   facelet_idx_t, color_t          - index and colour word types
//   scan_state_e                    - scan FSM states
package cube_pkg;

    localparam int NUM_FACELETS = 54;
    localparam int COLOR_W      = 30;
    localparam int IDX_W        = 7;

    typedef logic [IDX_W-1:0]   facelet_idx_t;
    typedef logic [COLOR_W-1:0] color_t;

    localparam color_t COLOR_RESET = '1;

    localparam facelet_idx_t FACE_U = 7'd0;
    localparam facelet_idx_t FACE_D = 7'd9;
    localparam facelet_idx_t FACE_B = 7'd18;
    localparam facelet_idx_t FACE_F = 7'd27;
    localparam facelet_idx_t FACE_L = 7'd36;
    localparam facelet_idx_t FACE_R = 7'd45;

    // Index-typed bounds so comparisons stay IDX_W wide and unsigned.
    localparam facelet_idx_t NUM_IDX  = facelet_idx_t'(NUM_FACELETS);
    localparam facelet_idx_t LAST_IDX = facelet_idx_t'(NUM_FACELETS - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        PRESENT
    } scan_state_e;

endpackage

// File: rtl/facelet_scan_scheduler_store.sv
// facelet_store: NUM_FACELETS x COLOR_W colour register file.
//   Clk, Reset_n      - clock, synchronous active-low reset (all entries -> COLOR_RESET)
//   we, waddr, wdata  - synchronous write port
//   raddr, rdata      - combinational read port (out-of-range reads return COLOR_RESET)
module facelet_store
    import cube_pkg::*;
(
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         we,
    input  facelet_idx_t waddr,
    input  color_t       wdata,
    input  facelet_idx_t raddr,
    output color_t       rdata
);

    localparam int ADDR_W = $clog2(NUM_FACELETS);

    color_t mem [NUM_FACELETS];

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            mem <= '{default: COLOR_RESET};
        end else if (we && (waddr < NUM_IDX)) begin
            mem[waddr[ADDR_W-1:0]] <= wdata;
        end
    end

    always_comb begin
        rdata = COLOR_RESET;
        if (raddr < NUM_IDX) begin
            rdata = mem[raddr[ADDR_W-1:0]];
        end
    end

endmodule

// File: rtl/facelet_scan_scheduler.sv
// facelet_scan_scheduler: owns the facelet colour store and shares its single
// access port between capture writes and the per-frame cube-map scan.
//   Clk, Reset_n            - clock, synchronous active-low reset
//   frame_start             - pulse; start scanning facelets 0..53
//   wr_req/wr_index/wr_color- capture write request, held until wr_ack
//   wr_ack, wr_err          - write performed; wr_err when wr_index out of range
//   scan_valid/scan_ready   - handshake for scan_index/scan_color pairs
//   scan_busy               - FSM not idle
//   scan_done               - pulse; last facelet accepted
//   frame_overrun           - pulse; frame_start arrived while busy
module facelet_scan_scheduler
    import cube_pkg::*;
#(
    parameter int STARVE_MAX = 4
)
(
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_start,
    input  logic               wr_req,
    input  logic [IDX_W-1:0]   wr_index,
    input  logic [COLOR_W-1:0] wr_color,
    output logic               wr_ack,
    output logic               wr_err,
    output logic               scan_valid,
    input  logic               scan_ready,
    output logic [IDX_W-1:0]   scan_index,
    output logic [COLOR_W-1:0] scan_color,
    output logic               scan_busy,
    output logic               scan_done,
    output logic               frame_overrun
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    scan_state_e         state;
    facelet_idx_t        ptr;
    logic [STARVE_W-1:0] starve_cnt;
    color_t              rd_color;

    logic read_req;
    logic write_gnt;
    logic read_gnt;
    logic index_ok;
    logic store_we;

    // Writes win the port unless the pending read has lost STARVE_MAX times in a row.
    always_comb begin
        read_req  = (state == READ);
        write_gnt = wr_req && !(read_req && (starve_cnt == STARVE_LIMIT));
        read_gnt  = read_req && !write_gnt;
        index_ok  = (wr_index < NUM_IDX);
        store_we  = write_gnt && index_ok;
    end

    assign scan_busy = (state != IDLE);

    facelet_store u_store (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .we      (store_we),
        .waddr   (wr_index),
        .wdata   (wr_color),
        .raddr   (ptr),
        .rdata   (rd_color)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state         <= IDLE;
            ptr           <= '0;
            starve_cnt    <= '0;
            wr_ack        <= 1'b0;
            wr_err        <= 1'b0;
            scan_valid    <= 1'b0;
            scan_index    <= '0;
            scan_color    <= '0;
            scan_done     <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            wr_ack        <= write_gnt;
            wr_err        <= write_gnt && !index_ok;
            scan_done     <= 1'b0;
            frame_overrun <= frame_start && (state != IDLE);

            // A READ cycle without a grant means the write took the port.
            if ((state != READ) || read_gnt) begin
                starve_cnt <= '0;
            end else begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        ptr   <= '0;
                        state <= READ;
                    end
                end
                READ: begin
                    if (read_gnt) begin
                        scan_color <= rd_color;
                        scan_index <= ptr;
                        scan_valid <= 1'b1;
                        state      <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (scan_valid && scan_ready) begin
                        scan_valid <= 1'b0;
                        if (ptr == LAST_IDX) begin
                            scan_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            state <= READ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_facelet_scan_scheduler.sv
module tb_facelet_scan_scheduler;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        wr_req = 1'b0;
    logic [6:0]  wr_index = '0;
    logic [29:0] wr_color = '0;
    logic        wr_ack;
    logic        wr_err;
    logic        scan_valid;
    logic        scan_ready = 1'b1;
    logic [6:0]  scan_index;
    logic [29:0] scan_color;
    logic        scan_busy;
    logic        scan_done;
    logic        frame_overrun;

    int checks = 0;
    int errors = 0;

    logic [29:0] exp_store [54];

    always #5 Clk = ~Clk;

    facelet_scan_scheduler #(.STARVE_MAX(4)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_start   (frame_start),
        .wr_req        (wr_req),
        .wr_index      (wr_index),
        .wr_color      (wr_color),
        .wr_ack        (wr_ack),
        .wr_err        (wr_err),
        .scan_valid    (scan_valid),
        .scan_ready    (scan_ready),
        .scan_index    (scan_index),
        .scan_color    (scan_color),
        .scan_busy     (scan_busy),
        .scan_done     (scan_done),
        .frame_overrun (frame_overrun)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_valid"}, 32'(scan_valid), 0);
        check({tag, "_index"}, 32'(scan_index), 0);
        check({tag, "_color"}, 32'(scan_color), 0);
        check({tag, "_busy"}, 32'(scan_busy), 0);
        check({tag, "_done"}, 32'(scan_done), 0);
        check({tag, "_ack"}, 32'(wr_ack), 0);
        check({tag, "_err"}, 32'(wr_err), 0);
        check({tag, "_ovr"}, 32'(frame_overrun), 0);
    endtask

    task automatic store_reset_model();
        for (int i = 0; i < 54; i++) exp_store[i] = 30'h3FFFFFFF;
    endtask

    // One frame scan. traffic: hold wr_req with rotating indices 0..8.
    // stall_idx/overrun_idx/abort_idx select the facelet for each event (-1 = none).
    task automatic run_scan(input bit traffic, input int stall_idx, input int overrun_idx,
                            input int abort_idx, input int exp_done);
        int nx = 0;
        int cyc = 0;
        int gap = 0;
        int acks = 0;
        int widx = 0;
        int done_cyc = -1;
        bit prev_v = 1'b0;
        bit ov_pending = 1'b0;
        logic [29:0] snap;
        if (traffic) begin
            wr_req   = 1'b1;
            wr_index = 7'd0;
            wr_color = 30'h0ABC000;
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("busy_after_start", 32'(scan_busy), 1);
        while (cyc < 1000) begin
            if (ov_pending) begin
                check("overrun_pulse", 32'(frame_overrun), 1);
                frame_start = 1'b0;
                ov_pending = 1'b0;
            end
            if (traffic && wr_ack) begin
                check("traffic_err", 32'(wr_err), 0);
                exp_store[wr_index] = wr_color;
                acks++;
                widx = (widx + 1) % 9;
                wr_index = 7'(widx);
                wr_color = 30'h0ABC000 + 30'(acks * 16 + widx);
            end
            if (scan_done) begin
                done_cyc = cyc;
                break;
            end
            if (scan_valid && !prev_v) begin
                snap = exp_store[nx];
                check($sformatf("idx_%0d", nx), 32'(scan_index), 32'(nx));
                check($sformatf("color_%0d", nx), 32'(scan_color), 32'(snap));
                check($sformatf("gap_%0d", nx), 32'(gap), traffic ? 5 : 1);
                if (nx == abort_idx) begin
                    Reset_n = 1'b0;
                    wr_req = 1'b1;
                    wr_index = 7'd3;
                    wr_color = 30'h0;
                    tick();
                    check_idle_zero("abort_reset");
                    Reset_n = 1'b1;
                    wr_req = 1'b0;
                    store_reset_model();
                    tick();
                    check("abort_no_done", 32'(scan_done), 0);
                    check("abort_no_ack", 32'(wr_ack), 0);
                    check("abort_idle", 32'(scan_busy), 0);
                    return;
                end
                if (nx == stall_idx) begin
                    scan_ready = 1'b0;
                    for (int s = 0; s < 10; s++) begin
                        tick();
                        cyc++;
                        check("stall_valid", 32'(scan_valid), 1);
                        check("stall_index", 32'(scan_index), 32'(stall_idx));
                        check("stall_color", 32'(scan_color), 32'(snap));
                    end
                    scan_ready = 1'b1;
                end
                if (nx == overrun_idx) begin
                    frame_start = 1'b1;
                    ov_pending = 1'b1;
                end
            end
            if (scan_valid && scan_ready) begin
                nx++;
                gap = -1;
            end
            prev_v = scan_valid;
            tick();
            cyc++;
            gap++;
        end
        if (traffic) begin
            wr_req = 1'b0;
            check("traffic_acks", 32'(acks), 271);
        end
        check("done_cycle", 32'(done_cyc), 32'(exp_done));
        check("transfers", 32'(nx), 54);
        tick();
        check("done_single_pulse", 32'(scan_done), 0);
        check("idle_after_scan", 32'(scan_busy), 0);
        check("valid_low_after_scan", 32'(scan_valid), 0);
    endtask

    task automatic single_write(input string tag, input logic [6:0] idx,
                                input logic [29:0] col, input bit exp_err);
        wr_req   = 1'b1;
        wr_index = idx;
        wr_color = col;
        tick();
        check({tag, "_ack"}, 32'(wr_ack), 1);
        check({tag, "_err"}, 32'(wr_err), 32'(exp_err));
        if (!exp_err) exp_store[idx] = col;
        wr_req = 1'b0;
        tick();
        check({tag, "_ack_drop"}, 32'(wr_ack), 0);
        check({tag, "_err_drop"}, 32'(wr_err), 0);
    endtask

    initial begin
        store_reset_model();

        // Reset state
        Reset_n = 1'b0;
        tick();
        tick();
        check_idle_zero("reset");
        Reset_n = 1'b1;
        tick();
        check_idle_zero("post_reset");

        // Plain scan of reset contents
        run_scan(1'b0, -1, -1, -1, 108);

        // Single write to facelet 31, visible in the next scan
        single_write("wr31", 7'd31, 30'h000003FF, 1'b0);
        run_scan(1'b0, -1, -1, -1, 108);

        // Continuous write pressure: scan starved exactly STARVE_MAX cycles per read
        run_scan(1'b1, -1, -1, -1, 324);

        // Downstream stall on facelet 5
        run_scan(1'b0, 5, -1, -1, 118);

        // Out-of-range writes leave the store unchanged
        single_write("wr54", 7'd54, 30'h12345678, 1'b1);
        single_write("wr127", 7'd127, 30'h0000FFFF, 1'b1);
        run_scan(1'b0, -1, -1, -1, 108);

        // Reset while facelet 20 is presented, then a clean scan from 0
        run_scan(1'b0, -1, -1, 20, 0);
        run_scan(1'b0, -1, -1, -1, 108);

        // frame_start mid-scan is ignored apart from the overrun pulse
        run_scan(1'b0, -1, 10, -1, 108);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/facelet_scan_scheduler.md
Name: facelet_scan_scheduler

Overview:
Owns the 54-entry facelet colour store and shares its single access port between the camera capture path (writes) and the on-screen cube-map scan (reads). On each frame start it walks facelet indices 0..53 in order (U 0-8, D 9-17, B 18-26, F 27-35, L 36-44, R 45-53). It presents each index/colour pair to the cube-map position block with a valid/ready handshake, so the map can redraw the cube every frame.

Parameters:
NUM_FACELETS, 54, number of facelets stored and scanned
COLOR_W, 30, colour word width (10-bit R,G,B)
IDX_W, 7, facelet index width
STARVE_MAX, 4, maximum consecutive cycles a pending scan read may lose arbitration before it wins

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous active-low reset
frame_start  in  1  one-cycle pulse; starts a scan of all facelets
wr_req  in  1  capture write request; held until wr_ack
wr_index  in  IDX_W  facelet to write; stable while wr_req
wr_color  in  COLOR_W  colour to write; stable while wr_req
wr_ack  out  1  one-cycle pulse; write performed at this clock edge
wr_err  out  1  one-cycle pulse with wr_ack when wr_index >= NUM_FACELETS
scan_valid  out  1  scan_index/scan_color valid
scan_ready  in  1  downstream accepts the current pair
scan_index  out  IDX_W  facelet index being presented
scan_color  out  COLOR_W  stored colour for scan_index
scan_busy  out  1  high whenever the FSM is not IDLE
scan_done  out  1  one-cycle pulse; facelet 53 was accepted
frame_overrun  out  1  one-cycle pulse; frame_start arrived while busy

Behaviour:
- Reset (Reset_n low at a Clk edge): all outputs 0. scan_index=0, scan_color=0. FSM=IDLE. Starvation counter=0. All 54 store entries = all-ones (30'h3FFFFFFF).
- FSM states: IDLE, READ, PRESENT.
- IDLE: frame_start -> READ, ptr=0. Other inputs leave the state unchanged.
- READ: requests the store port. If granted, at that edge scan_color <= store[ptr], scan_index <= ptr, scan_valid <= 1, -> PRESENT. If not granted, stays in READ and the starvation counter increments.
- PRESENT: holds scan_valid, scan_index and scan_color stable while scan_ready=0.
  - On valid & ready with ptr<53: scan_valid <= 0, ptr+1, -> READ.
  - On valid & ready with ptr==53: scan_valid <= 0, scan_done <= 1, -> IDLE.
- Unstalled latency: frame_start at edge t -> READ after t; first valid after t+1. With scan_ready tied high, each facelet takes 2 cycles. scan_done is high for 1 cycle 108 cycles after frame_start.
- Arbitration (one store access per cycle):
  - A write wins over a scan read unless the starvation counter == STARVE_MAX; then the scan read wins and the write waits.
  - The counter clears on any scan grant and whenever the FSM is not in READ.
  - A write with no competing read is granted in the same cycle wr_req is seen.
- Write: on grant, wr_ack=1 for one cycle.
  - wr_index < 54: store[wr_index] <= wr_color at that edge.
  - wr_index >= 54: no store change; wr_err=1 with wr_ack.
  - The requester must drop wr_req or present new data after wr_ack. The next write may be acked the cycle after.
- Ordering: the store is written only on wr_ack edges. A scan read granted later sees the new value; a read of the same index granted earlier sees the old value. Reads and writes are never granted in the same cycle.
- frame_start while scan_busy: ignored (the scan is not restarted) and frame_overrun pulses for 1 cycle.
- Reset mid-operation overrides everything: the scan aborts, no scan_done, a pending write is dropped without ack, and the store is re-initialised to all-ones.
- ptr never exceeds 53. Index arithmetic is IDX_W unsigned; the comparisons against 53/54 are unsigned.

Decomposition:
- Shared package cube_pkg holds:
  - NUM_FACELETS, COLOR_W, IDX_W
  - COLOR_RESET (all-ones)
  - face base constants FACE_U=0, FACE_D=9, FACE_B=18, FACE_F=27, FACE_L=36, FACE_R=45
  - typedefs facelet_idx_t (logic [IDX_W-1:0]) and color_t (logic [COLOR_W-1:0])
  - scan state enum scan_state_e {IDLE, READ, PRESENT}
- One sub-module, facelet_store: 54 x COLOR_W register file with one synchronous write port, one combinational read port, and sync active-low reset to COLOR_RESET. The arbiter and FSM stay in the top module.

Test Plan:
- Reset, then frame_start with scan_ready=1 -> 54 transfers, indices 0..53 in order, every scan_color=30'h3FFFFFFF; scan_done pulses once, 108 cycles after frame_start.
- Write idx 31 colour 30'h000003FF (wr_ack next-cycle observable), then frame_start -> transfer 31 carries 30'h000003FF; all others are all-ones.
- Hold wr_req high during a scan (rotating indices 0..8), STARVE_MAX=4 -> scan gets a grant after at most 4 lost cycles per facelet; every write acked; scan completes with 54 transfers.
- scan_ready low for 10 cycles while index 5 is presented -> scan_valid, scan_index=5 and scan_color held stable for all 10 cycles; index 6 follows after acceptance.
- wr_index=54, then 127 -> wr_ack and wr_err each pulse once; the next full scan shows the store unchanged.
- Reset_n low while index 20 is presented, plus a frame_start during a scan on a separate run -> reset: outputs zero, store all-ones, no scan_done, next scan starts at 0; mid-scan frame_start: frame_overrun pulse, scan continues uninterrupted.
